// File: rtl/key_pkg.sv
// Shared key indices, counts and the auto-repeat phase type.
// Used by the key conditioner, its debounce channels and the pulse interface.
package key_pkg;

    localparam int N_KEYS   = 3;
    localparam int N_REPEAT = 2;

    localparam int KEY_NEXT = 0;
    localparam int KEY_PRE  = 1;
    localparam int KEY_AUTO = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        PERIOD = 2'd2
    } rep_phase_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Command pulse bundle from the key conditioner to the slide selector.
// Pulses are single-cycle and unacknowledged; key_level is a debounced level.
interface key_conditioner_if;
    import key_pkg::*;

    logic              bt_next;
    logic              bt_pre;
    logic              bt_auto;
    logic [N_KEYS-1:0] key_level;

    modport master (output bt_next, output bt_pre, output bt_auto, output key_level);
    modport slave  (input  bt_next, input  bt_pre, input  bt_auto, input  key_level);

endinterface

// File: rtl/key_debounce_ch.sv
// One key: 2-flop synchroniser, stability-count debounce, press-event flag.
// Raw edge to key_level change is 2 + DEBOUNCE_CYCLES cycles; no backpressure.
module key_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 28
) (
    input  logic sysclk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic press_evt
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             settled;

    assign differ  = sync2 ^ key_level;
    assign settled = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            key_level <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            // Any cycle back at the current level restarts the stability count.
            if (!differ || settled) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (settled) begin
                key_level <= ~key_level;
            end
            press_evt <= settled & ~key_level;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Turns three raw buttons into clean single-cycle next/pre/auto command pulses.
// Pulse follows the debounced press by one cycle; hold auto-repeats next/pre; no backpressure.
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 12_500_000,
    parameter int CNT_W           = 28
) (
    input  logic              sysclk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    key_conditioner_if.master kif
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
    localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 2) && (REPEAT_DELAY >= 0) &&
                               (REPEAT_PERIOD >= 1) &&
                               (longint'(DEBOUNCE_CYCLES) <= CNT_MAX) &&
                               (longint'(REPEAT_DELAY) <= CNT_MAX) &&
                               (longint'(REPEAT_PERIOD) <= CNT_MAX);

    param_chk: assert property (@(posedge sysclk) PARAMS_OK);

    logic [N_KEYS-1:0]   level;
    logic [N_KEYS-1:0]   press;
    logic [N_REPEAT-1:0] rep;
    logic                next_p;
    logic                pre_p;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .sysclk    (sysclk),
            .sys_rst_n (sys_rst_n),
            .key_raw   (key_raw[i]),
            .key_level (level[i]),
            .press_evt (press[i])
        );
    end

    for (genvar i = 0; i < N_REPEAT; i++) begin : g_rep
        rep_phase_t       phase_q;
        rep_phase_t       phase_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             delay_done;
        logic             period_done;
        logic             rep_hit;

        assign delay_done  = (phase_q == DELAY)  && (cnt_q == CNT_W'(REPEAT_DELAY - 1));
        assign period_done = (phase_q == PERIOD) && (cnt_q == CNT_W'(REPEAT_PERIOD - 1));

        always_ff @(posedge sysclk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                phase_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                phase_q <= phase_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            phase_d = phase_q;
            cnt_d   = cnt_q;
            if (!level[i]) begin
                phase_d = IDLE;
                cnt_d   = '0;
            end else if (press[i]) begin
                phase_d = (REPEAT_DELAY == 0) ? IDLE : DELAY;
                cnt_d   = '0;
            end else begin
                case (phase_q)
                    DELAY: begin
                        if (delay_done) begin
                            phase_d = PERIOD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    PERIOD: begin
                        if (period_done) begin
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: cnt_d = '0;
                endcase
            end
        end

        // A repeat landing on the release cycle is dropped by the level gate.
        always_comb begin
            rep_hit = level[i] && !press[i] && (delay_done || period_done);
        end

        assign rep[i] = rep_hit;
    end

    assign next_p = press[KEY_NEXT] | rep[KEY_NEXT];
    assign pre_p  = press[KEY_PRE]  | rep[KEY_PRE];

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            kif.bt_next <= 1'b0;
            kif.bt_pre  <= 1'b0;
            kif.bt_auto <= 1'b0;
        end else begin
            kif.bt_next <= next_p & ~pre_p;
            kif.bt_pre  <= pre_p & ~next_p;
            kif.bt_auto <= press[KEY_AUTO];
        end
    end

    assign kif.key_level = level;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.
// Cycle c is the period after the c-th rising edge counted from stimulus start.
module tb_key_conditioner;

    logic       sysclk;
    logic       sys_rst_n;
    logic [2:0] key_raw;
    int         total  = 0;
    int         passes = 0;

    key_conditioner_if kif ();

    key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .CNT_W           (28)
    ) dut (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .key_raw   (key_raw),
        .kif       (kif)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Vector order: {bt_next, bt_pre, bt_auto, key_level[2:0]}
    task automatic chk(input string tag, input int c, input logic [5:0] exp_v);
        logic [5:0] obs;
        obs = {kif.bt_next, kif.bt_pre, kif.bt_auto, kif.key_level};
        total++;
        assert (obs === exp_v) begin
            passes++;
        end else begin
            $error("FAIL %s cycle %0d: got %b want %b", tag, c, obs, exp_v);
        end
    endtask

    task automatic do_reset(input string tag);
        key_raw   = 3'b000;
        sys_rst_n = 1'b0;
        step();
        step();
        chk({tag, "_in_reset"}, 0, 6'b000000);
        sys_rst_n = 1'b1;
        step();
        step();
        chk({tag, "_idle"}, 0, 6'b000000);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_raw   = 3'b000;

        // Clean press on next, released at cycle 10
        do_reset("clean");
        key_raw[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("clean", c, {c == 7, 1'b0, 1'b0, 2'b00, (c >= 6 && c < 16)});
            key_raw[0] = (c < 10);
        end

        // Bounce on pre every 2 cycles, settles high at cycle 12, released at 24
        do_reset("bounce");
        key_raw[1] = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            step();
            chk("bounce", c, {1'b0, c == 19, 1'b0, 1'b0, (c >= 18 && c < 30), 1'b0});
            key_raw[1] = (c < 12) ? ((c / 2) % 2 == 0) : (c < 24);
        end

        // Auto-repeat on next, held cycles 0..59
        do_reset("repeat");
        key_raw[0] = 1'b1;
        for (int c = 1; c <= 75; c++) begin
            step();
            chk("repeat", c, {(c == 7 || c == 27 || c == 35 || c == 43 || c == 51 || c == 59),
                              1'b0, 1'b0, 2'b00, (c >= 6 && c < 66)});
            key_raw[0] = (c < 60);
        end

        // Auto key held: one pulse, never repeats
        do_reset("auto_hold");
        key_raw[2] = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            step();
            chk("auto_hold", c, {1'b0, 1'b0, c == 7, (c >= 6 && c < 66), 2'b00});
            key_raw[2] = (c < 60);
        end

        // Next and pre together: both pulses suppressed
        do_reset("conflict");
        key_raw = 3'b011;
        for (int c = 1; c <= 16; c++) begin
            step();
            chk("conflict", c, {3'b000, 1'b0, (c >= 6 && c < 11), (c >= 6 && c < 11)});
            key_raw = (c < 5) ? 3'b011 : 3'b000;
        end

        // Reset asserted at cycle 30 for 3 cycles while next is held
        do_reset("rst_mid");
        key_raw[0] = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            step();
            if (c <= 30) begin
                chk("rst_mid_pre", c, {(c == 7 || c == 27), 1'b0, 1'b0, 2'b00, c >= 6});
            end else if (c <= 38) begin
                chk("rst_mid_hold", c, 6'b000000);
            end else begin
                chk("rst_mid_post", c, {c == 40, 1'b0, 1'b0, 2'b00, 1'b1});
            end
            if (c == 30) begin
                sys_rst_n = 1'b0;
                #1;
                chk("rst_mid_async", c, 6'b000000);
            end
            if (c == 33) begin
                sys_rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
